// File: rtl/door_pkg.sv
// Shared door state encoding and counter sizing for the elevator door controller.
package door_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } door_state_t;

  // Largest value ever loaded is max(transit, dwell) - 1.
  function automatic int cnt_width(input int transit, input int dwell);
    int m;
    m = (transit > dwell) ? transit : dwell;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/door_call_latch.sv
// Per-floor call latch: set by call_req, cleared by a serve (clear wins), with a
// mask dropping requests for the floor whose door is currently not closed.
module call_latch #(
  parameter int N_FLOORS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic [N_FLOORS-1:0] call_clr,
  input  logic [N_FLOORS-1:0] call_mask,
  output logic [N_FLOORS-1:0] call_led
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      call_led <= '0;
    end else begin
      call_led <= (call_led | (call_req & ~call_mask)) & ~call_clr;
    end
  end

endmodule

// File: rtl/door_controller.sv
// N-floor elevator door controller: latches calls, runs open/dwell/close sequence.
// Door opens one cycle after the open condition; move_enable decoded from state.
module door_controller
  import door_pkg::*;
#(
  parameter int N_FLOORS       = 4,
  parameter int FLOOR_W        = $clog2(N_FLOORS),
  parameter int TRANSIT_CYCLES = 4,
  parameter int DWELL_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FLOOR_W-1:0]  floor,
  input  logic                car_stopped,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic                sos_mode,
  input  logic                obstruction,
  input  logic                open_btn,
  input  logic                close_btn,
  output logic [1:0]          door_state,
  output logic [N_FLOORS-1:0] call_led,
  output logic [N_FLOORS-1:0] call_served,
  output logic                move_enable
);

  localparam int                  CNT_W        = cnt_width(TRANSIT_CYCLES, DWELL_CYCLES);
  localparam logic [CNT_W-1:0]    TRANSIT_LOAD = CNT_W'(TRANSIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    DWELL_LOAD   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE      = CNT_W'(1);
  localparam logic [N_FLOORS-1:0] FLOOR_ONE    = {{(N_FLOORS-1){1'b0}}, 1'b1};

  door_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_FLOORS-1:0] floor_oh;
  logic [N_FLOORS-1:0] serve_d;
  logic [N_FLOORS-1:0] served_q;
  logic [N_FLOORS-1:0] call_mask;
  logic                floor_valid;
  logic                call_here;
  logic                open_go;

  // An out-of-range floor decodes to no floor at all, so it can neither open nor serve.
  assign floor_valid = int'(floor) < N_FLOORS;
  assign floor_oh    = floor_valid ? (FLOOR_ONE << floor) : '0;
  assign call_here   = |(call_led & floor_oh);

  assign open_go = (state_q == CLOSED) && car_stopped && !sos_mode && floor_valid &&
                   (call_here || open_btn);

  assign serve_d   = open_go ? (call_led & floor_oh) : '0;
  assign call_mask = (state_q != CLOSED) ? floor_oh : '0;

  call_latch #(
    .N_FLOORS (N_FLOORS)
  ) u_call_latch (
    .clk       (clk),
    .rst       (rst),
    .call_req  (call_req),
    .call_clr  (serve_d),
    .call_mask (call_mask),
    .call_led  (call_led)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLOSED;
      cnt_q    <= '0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      served_q <= serve_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLOSED: begin
        if (open_go) begin
          state_d = OPENING;
          cnt_d   = TRANSIT_LOAD;
        end
      end

      OPENING: begin
        if (sos_mode && !obstruction) begin
          state_d = CLOSING;
          cnt_d   = TRANSIT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = OPEN;
          cnt_d   = DWELL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      // Obstruction beats every close request; open_btn beats close_btn.
      OPEN: begin
        if (obstruction) begin
          cnt_d = DWELL_LOAD;
        end else if (sos_mode) begin
          state_d = CLOSING;
          cnt_d   = TRANSIT_LOAD;
        end else if (open_btn) begin
          cnt_d = DWELL_LOAD;
        end else if (close_btn || (cnt_q == '0)) begin
          state_d = CLOSING;
          cnt_d   = TRANSIT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      // Obstruction reopens even while the emergency is closing the door.
      CLOSING: begin
        if (obstruction || (open_btn && !sos_mode)) begin
          state_d = OPENING;
          cnt_d   = TRANSIT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = CLOSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = CLOSED;
        cnt_d   = '0;
      end
    endcase
  end

  assign door_state  = state_q;
  assign call_served = served_q;
  assign move_enable = (state_q == CLOSED);

endmodule

// File: tb/tb_door_controller.sv
// Directed bench for door_controller: call serve, obstruction, emergency, buttons, boundaries.
module tb_door_controller;
  import door_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] floor;
  logic       car_stopped;
  logic [3:0] call_req;
  logic       sos_mode;
  logic       obstruction;
  logic       open_btn;
  logic       close_btn;
  logic [1:0] door_state;
  logic [3:0] call_led;
  logic [3:0] call_served;
  logic       move_enable;

  // Three-floor instance for the invalid-floor boundary.
  logic [1:0] floor3;
  logic       car_stopped3;
  logic [2:0] call_req3;
  logic       open_btn3;
  logic       idle3;
  logic [1:0] door_state3;
  logic [2:0] call_led3;
  logic [2:0] call_served3;
  logic       move_enable3;

  int n_checks = 0;
  int n_errors = 0;

  door_controller #(
    .N_FLOORS       (4),
    .TRANSIT_CYCLES (4),
    .DWELL_CYCLES   (16)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .floor       (floor),
    .car_stopped (car_stopped),
    .call_req    (call_req),
    .sos_mode    (sos_mode),
    .obstruction (obstruction),
    .open_btn    (open_btn),
    .close_btn   (close_btn),
    .door_state  (door_state),
    .call_led    (call_led),
    .call_served (call_served),
    .move_enable (move_enable)
  );

  door_controller #(
    .N_FLOORS       (3),
    .TRANSIT_CYCLES (2),
    .DWELL_CYCLES   (3)
  ) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .floor       (floor3),
    .car_stopped (car_stopped3),
    .call_req    (call_req3),
    .sos_mode    (idle3),
    .obstruction (idle3),
    .open_btn    (open_btn3),
    .close_btn   (idle3),
    .door_state  (door_state3),
    .call_led    (call_led3),
    .call_served (call_served3),
    .move_enable (move_enable3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks door_state for n consecutive cycles, leaving the bench one cycle later.
  task automatic expect_state(input string tag, input logic [1:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(door_state), 32'(st));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    floor = 2'd0; car_stopped = 1'b0; call_req = 4'b0000;
    sos_mode = 1'b0; obstruction = 1'b0; open_btn = 1'b0; close_btn = 1'b0;
    floor3 = 2'd0; car_stopped3 = 1'b0; call_req3 = 3'b000; open_btn3 = 1'b0; idle3 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(door_state), 32'(CLOSED));
    check("rst_led", 32'(call_led), 32'h0);
    check("rst_served", 32'(call_served), 32'h0);
    check("rst_move_en", 32'(move_enable), 32'h1);
    rst = 1'b0;
    tick();

    // Basic call at floor 2
    floor = 2'd2; car_stopped = 1'b1; call_req = 4'b0100;
    tick();
    call_req = 4'b0000;
    check("basic_led_set", 32'(call_led), 32'h4);
    check("basic_still_closed", 32'(door_state), 32'(CLOSED));
    tick();
    check("basic_opening", 32'(door_state), 32'(OPENING));
    check("basic_served", 32'(call_served), 32'h4);
    check("basic_led_clr", 32'(call_led), 32'h0);
    check("basic_move_dis", 32'(move_enable), 32'h0);
    tick();
    check("basic_served_pulse", 32'(call_served), 32'h0);
    expect_state("basic_opening_len", OPENING, 3);
    expect_state("basic_open_len", OPEN, 16);
    expect_state("basic_closing_len", CLOSING, 4);
    check("basic_closed", 32'(door_state), 32'(CLOSED));
    check("basic_move_en", 32'(move_enable), 32'h1);
    check("basic_led_final", 32'(call_led), 32'h0);

    // Obstruction in the 2nd closing cycle
    open_btn = 1'b1;
    tick();
    open_btn = 1'b0;
    expect_state("obs_opening", OPENING, 4);
    expect_state("obs_open", OPEN, 16);
    check("obs_closing1", 32'(door_state), 32'(CLOSING));
    tick();
    check("obs_closing2", 32'(door_state), 32'(CLOSING));
    obstruction = 1'b1;
    tick();
    expect_state("obs_reopen", OPENING, 4);
    expect_state("obs_held_open", OPEN, 20);
    obstruction = 1'b0;
    expect_state("obs_dwell", OPEN, 16);
    expect_state("obs_closing", CLOSING, 4);
    check("obs_closed", 32'(door_state), 32'(CLOSED));

    // Emergency during OPEN
    open_btn = 1'b1;
    tick();
    open_btn = 1'b0;
    expect_state("sos_opening", OPENING, 4);
    expect_state("sos_open", OPEN, 3);
    sos_mode = 1'b1;
    tick();
    expect_state("sos_closing", CLOSING, 4);
    check("sos_closed", 32'(door_state), 32'(CLOSED));
    call_req = 4'b0100;
    tick();
    call_req = 4'b0000;
    check("sos_call_led", 32'(call_led), 32'h4);
    check("sos_call_closed", 32'(door_state), 32'(CLOSED));
    tick();
    tick();
    check("sos_locked", 32'(door_state), 32'(CLOSED));
    check("sos_led_kept", 32'(call_led), 32'h4);
    check("sos_move_en", 32'(move_enable), 32'h1);
    sos_mode = 1'b0;
    tick();
    check("sos_release_open", 32'(door_state), 32'(OPENING));
    check("sos_release_served", 32'(call_served), 32'h4);
    expect_state("btn_opening", OPENING, 4);

    // Same-floor call during OPEN is dropped
    call_req = 4'b0100;
    tick();
    call_req = 4'b0000;
    check("mask_led", 32'(call_led), 32'h0);
    check("mask_open", 32'(door_state), 32'(OPEN));

    // Buttons
    close_btn = 1'b1;
    tick();
    close_btn = 1'b0;
    check("close_btn_closing", 32'(door_state), 32'(CLOSING));
    tick();
    open_btn = 1'b1;
    tick();
    open_btn = 1'b0;
    expect_state("open_btn_reopen", OPENING, 4);
    expect_state("both_pre", OPEN, 5);
    open_btn = 1'b1; close_btn = 1'b1;
    tick();
    open_btn = 1'b0; close_btn = 1'b0;
    expect_state("both_reload", OPEN, 16);
    expect_state("both_closing", CLOSING, 4);
    check("both_closed", 32'(door_state), 32'(CLOSED));

    // Invalid floor on the three-floor car
    floor3 = 2'd3; car_stopped3 = 1'b1; open_btn3 = 1'b1; call_req3 = 3'b001;
    tick();
    call_req3 = 3'b000;
    check("inv_led", 32'(call_led3), 32'h1);
    expect_state("inv_dummy_main", CLOSED, 1);
    for (int i = 0; i < 3; i++) begin
      check("inv_closed", 32'(door_state3), 32'(CLOSED));
      tick();
    end
    check("inv_move_en", 32'(move_enable3), 32'h1);
    check("inv_led_kept", 32'(call_led3), 32'h1);
    floor3 = 2'd0;
    tick();
    open_btn3 = 1'b0;
    check("inv_valid_open", 32'(door_state3), 32'(OPENING));
    check("inv_valid_served", 32'(call_served3), 32'h1);

    // Async reset mid-OPENING
    call_req = 4'b1000;
    tick();
    call_req = 4'b0000;
    check("arst_led_pre", 32'(call_led), 32'h8);
    open_btn = 1'b1;
    tick();
    open_btn = 1'b0;
    tick();
    check("arst_opening_pre", 32'(door_state), 32'(OPENING));
    #2;
    rst = 1'b1;
    #1;
    check("arst_closed", 32'(door_state), 32'(CLOSED));
    check("arst_led", 32'(call_led), 32'h0);
    check("arst_move_en", 32'(move_enable), 32'h1);
    check("arst_served", 32'(call_served), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
